bolucu: RTL and testbench

// - Iterative radix-2 restoring integer divider; the sequential counterpart of the combinational multiplier in the execute stage.
// - Serves RISC-V M-extension DIV/DIVU/REM/REMU; produces quotient and remainder together.
// - Handshake is ready/valid: the execute stage stalls while hazir_o is low and takes results when sonuc_gecerli_o pulses.

---
 rtl/bolucu_if.sv | 38 +++
 rtl/bolucu.sv | 166 ++++++++++++++++
 tb/tb_bolucu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bolucu_if.sv
// -----------------------------------------------------------------------------
// bolucu_if
// Purpose : ready/valid bundle between the execute stage and the iterative
//           divider (bolucu).
// Signals : islem_gecerli_i  start request (execute -> divider)
//           islem_isaretli_i 1 = signed DIV/REM, 0 = unsigned DIVU/REMU
//           islec0_i         dividend
//           islec1_i         divisor
//           iptal_i          flush / abort the operation in flight
//           hazir_o          divider idle, new operation may be accepted
//           bolum_o          quotient (registered)
//           kalan_o          remainder (registered)
//           sonuc_gecerli_o  one-cycle pulse, bolum_o/kalan_o valid
// Modports: master = execute stage side, slave = divider side.
// -----------------------------------------------------------------------------
interface bolucu_if #(
  parameter int XLEN = 32
);
  logic            islem_gecerli_i;
  logic            islem_isaretli_i;
  logic [XLEN-1:0] islec0_i;
  logic [XLEN-1:0] islec1_i;
  logic            iptal_i;
  logic            hazir_o;
  logic [XLEN-1:0] bolum_o;
  logic [XLEN-1:0] kalan_o;
  logic            sonuc_gecerli_o;

  modport master (
    output islem_gecerli_i, islem_isaretli_i, islec0_i, islec1_i, iptal_i,
    input  hazir_o, bolum_o, kalan_o, sonuc_gecerli_o
  );

  modport slave (
    input  islem_gecerli_i, islem_isaretli_i, islec0_i, islec1_i, iptal_i,
    output hazir_o, bolum_o, kalan_o, sonuc_gecerli_o
  );
endinterface

// File: rtl/bolucu.sv
// -----------------------------------------------------------------------------
// bolucu
// Purpose : iterative radix-2 restoring integer divider for RISC-V
//           DIV/DIVU/REM/REMU. Produces quotient and remainder together,
//           one quotient bit per cycle.
// Ports   : clk_i  clock, rising edge
//           rst_i  asynchronous active-high reset
//           bus    bolucu_if.slave (start request, operands, flush,
//                  ready, results, result-valid pulse)
// Timing  : normal op result valid XLEN+2 edges after accept (counting the
//           accept edge); divide-by-zero and signed overflow take 2 edges.
// -----------------------------------------------------------------------------
module bolucu #(
  parameter int XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  bolucu_if.slave  bus
);

  localparam int SW = $clog2(XLEN);

  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] BOL    = 2'd1;
  localparam logic [1:0] DUZELT = 2'd2;
  localparam logic [1:0] OZEL   = 2'd3;

  localparam logic [XLEN-1:0] EN_KUCUK = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      durum_q, durum_d;
  logic [SW-1:0]   sayac_q, sayac_d;
  logic [XLEN-1:0] rem_q, rem_d;         // partial remainder (magnitude)
  logic [XLEN-1:0] q_q, q_d;             // dividend shifting out / quotient in
  logic [XLEN-1:0] bolen_q, bolen_d;     // |divisor|
  logic            neg_bolum_q, neg_bolum_d;
  logic            neg_kalan_q, neg_kalan_d;
  logic [XLEN-1:0] bolum_q, bolum_d;
  logic [XLEN-1:0] kalan_q, kalan_d;
  logic            gecerli_q, gecerli_d;

  // Operand preparation at accept time.
  logic            neg0, neg1, sifir_bolen, tasma;
  logic [XLEN-1:0] abs0, abs1;

  assign neg0        = bus.islem_isaretli_i & bus.islec0_i[XLEN-1];
  assign neg1        = bus.islem_isaretli_i & bus.islec1_i[XLEN-1];
  assign abs0        = neg0 ? -bus.islec0_i : bus.islec0_i;
  assign abs1        = neg1 ? -bus.islec1_i : bus.islec1_i;
  assign sifir_bolen = (bus.islec1_i == '0);
  assign tasma       = bus.islem_isaretli_i && (bus.islec0_i == EN_KUCUK) &&
                       (bus.islec1_i == '1);

  // One restoring step on an XLEN+1 bit remainder so the compare/subtract
  // never loses the bit shifted out of the top.
  logic [XLEN:0] rem_kay, rem_fark;
  logic          rem_buyuk;
  logic          unused_fark_msb;

  assign rem_kay   = {rem_q, q_q[XLEN-1]};
  assign rem_fark  = rem_kay - {1'b0, bolen_q};
  assign rem_buyuk = (rem_kay >= {1'b0, bolen_q});
  // When the subtraction is taken the difference is below |divisor|, so its
  // top bit is always zero.
  assign unused_fark_msb = rem_fark[XLEN];

  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    rem_d       = rem_q;
    q_d         = q_q;
    bolen_d     = bolen_q;
    neg_bolum_d = neg_bolum_q;
    neg_kalan_d = neg_kalan_q;
    bolum_d     = bolum_q;
    kalan_d     = kalan_q;
    gecerli_d   = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (bus.islem_gecerli_i) begin
          neg_bolum_d = neg0 ^ neg1;
          neg_kalan_d = neg0;
          bolen_d     = abs1;
          sayac_d     = SW'(XLEN - 1);
          if (sifir_bolen) begin
            // Special results are parked in q/rem and copied out in OZEL.
            q_d     = '1;
            rem_d   = bus.islec0_i;
            durum_d = OZEL;
          end else if (tasma) begin
            q_d     = bus.islec0_i;
            rem_d   = '0;
            durum_d = OZEL;
          end else begin
            q_d     = abs0;
            rem_d   = '0;
            durum_d = BOL;
          end
        end
      end
      BOL: begin
        q_d   = {q_q[XLEN-2:0], rem_buyuk};
        rem_d = rem_buyuk ? rem_fark[XLEN-1:0] : rem_kay[XLEN-1:0];
        if (sayac_q == '0) begin
          durum_d = DUZELT;
        end else begin
          sayac_d = sayac_q - SW'(1);
        end
      end
      DUZELT: begin
        bolum_d   = neg_bolum_q ? -q_q : q_q;
        kalan_d   = neg_kalan_q ? -rem_q : rem_q;
        gecerli_d = 1'b1;
        durum_d   = BOSTA;
      end
      OZEL: begin
        bolum_d   = q_q;
        kalan_d   = rem_q;
        gecerli_d = 1'b1;
        durum_d   = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase

    // Flush wins over everything, including an accept in the same cycle and
    // a result that would otherwise be registered this edge.
    if (bus.iptal_i) begin
      durum_d   = BOSTA;
      gecerli_d = 1'b0;
      bolum_d   = bolum_q;
      kalan_d   = kalan_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      sayac_q     <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      bolen_q     <= '0;
      neg_bolum_q <= 1'b0;
      neg_kalan_q <= 1'b0;
      bolum_q     <= '0;
      kalan_q     <= '0;
      gecerli_q   <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      sayac_q     <= sayac_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      bolen_q     <= bolen_d;
      neg_bolum_q <= neg_bolum_d;
      neg_kalan_q <= neg_kalan_d;
      bolum_q     <= bolum_d;
      kalan_q     <= kalan_d;
      gecerli_q   <= gecerli_d;
    end
  end

  assign bus.hazir_o         = (durum_q == BOSTA);
  assign bus.bolum_o         = bolum_q;
  assign bus.kalan_o         = kalan_q;
  assign bus.sonuc_gecerli_o = gecerli_q;

endmodule

// File: tb/tb_bolucu.sv
// -----------------------------------------------------------------------------
// tb_bolucu
// Purpose : directed self-checking bench for bolucu (XLEN = 32).
// -----------------------------------------------------------------------------
module tb_bolucu;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  bolucu_if #(.XLEN(XLEN)) bus ();

  bolucu #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Drives a request at the current time and releases it after the next
  // rising edge (the accept edge). Operands are scrambled while busy.
  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.islem_gecerli_i  = 1'b1;
    bus.islem_isaretli_i = sgn;
    bus.islec0_i         = a;
    bus.islec1_i         = b;
    @(posedge clk);
    #1;
    bus.islem_gecerli_i  = 1'b0;
    bus.islem_isaretli_i = ~sgn;
    bus.islec0_i         = $urandom;
    bus.islec1_i         = $urandom;
  endtask

  // Edges from accept (accept edge counts as 1) until the valid pulse;
  // returns 0 if no pulse within the budget.
  task automatic wait_valid(output int lat);
    int n;
    n   = 1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.sonuc_gecerli_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input int elat);
    int lat;
    @(negedge clk);
    start(sgn, a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_bolum"}, bus.bolum_o, eq);
    chk({tag, "_kalan"}, bus.kalan_o, er);
    $display("op %s sgn=%0b a=0x%h b=0x%h -> bolum=0x%h kalan=0x%h lat=%0d",
             tag, sgn, a, b, bus.bolum_o, bus.kalan_o, lat);
  endtask

  task automatic no_pulse(input string tag, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.sonuc_gecerli_o) c++;
    end
    chk(tag, c, 0);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.islem_gecerli_i  = 1'b0;
    bus.islem_isaretli_i = 1'b0;
    bus.islec0_i         = '0;
    bus.islec1_i         = '0;
    bus.iptal_i          = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hazir", {31'd0, bus.hazir_o}, 32'd1);
    chk("rst_gecerli", {31'd0, bus.sonuc_gecerli_o}, 32'd0);
    chk("rst_bolum", bus.bolum_o, 32'd0);
    chk("rst_kalan", bus.kalan_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned 100/7, also check busy flag and one-cycle pulse
    @(negedge clk);
    start(1'b0, 32'd100, 32'd7);
    chk("busy_after_accept", {31'd0, bus.hazir_o}, 32'd0);
    wait_valid(lat);
    chk("u100_7_lat", lat, 34);
    chk("u100_7_bolum", bus.bolum_o, 32'd14);
    chk("u100_7_kalan", bus.kalan_o, 32'd2);
    chk("u100_7_hazir", {31'd0, bus.hazir_o}, 32'd1);
    $display("op u100_7 -> bolum=0x%h kalan=0x%h lat=%0d", bus.bolum_o, bus.kalan_o, lat);
    @(posedge clk);
    #1;
    chk("pulse_one_cycle", {31'd0, bus.sonuc_gecerli_o}, 32'd0);

    run("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run("s_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34);
    run("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34);
    run("u_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         34);
    run("u_dz",    1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 2);
    run("s_dz",    1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 2);
    run("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         2);
    run("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 34);

    // Back-to-back: 100/7 then 9/3 accepted in the valid cycle
    @(negedge clk);
    start(1'b0, 32'd100, 32'd7);
    wait_valid(lat);
    chk("b2b_first_bolum", bus.bolum_o, 32'd14);
    start(1'b0, 32'd9, 32'd3);
    chk("b2b_accepted", {31'd0, bus.hazir_o}, 32'd0);
    chk("b2b_hold_bolum", bus.bolum_o, 32'd14);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_hold_kalan", bus.kalan_o, 32'd2);
    wait_valid(lat);
    chk("b2b_second_lat", lat, 34 - 20);
    chk("b2b_second_bolum", bus.bolum_o, 32'd3);
    chk("b2b_second_kalan", bus.kalan_o, 32'd0);
    $display("op b2b 9/3 -> bolum=0x%h kalan=0x%h", bus.bolum_o, bus.kalan_o);

    // Flush at cycle 10 of 1000/7: results hold 3/0, no pulse
    @(negedge clk);
    start(1'b0, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.iptal_i = 1'b1;
    @(posedge clk);
    #1;
    bus.iptal_i = 1'b0;
    chk("iptal_hazir", {31'd0, bus.hazir_o}, 32'd1);
    chk("iptal_hold_bolum", bus.bolum_o, 32'd3);
    chk("iptal_hold_kalan", bus.kalan_o, 32'd0);
    no_pulse("iptal_no_pulse", 40);
    $display("op iptal mid-op -> hazir=%0b bolum=0x%h kalan=0x%h", bus.hazir_o, bus.bolum_o, bus.kalan_o);

    // Flush together with a request: request dropped
    @(negedge clk);
    bus.iptal_i = 1'b1;
    start(1'b0, 32'd50, 32'd5);
    bus.iptal_i = 1'b0;
    chk("iptal_accept_dropped", {31'd0, bus.hazir_o}, 32'd1);
    no_pulse("iptal_accept_no_pulse", 40);

    // Async reset mid-operation
    @(negedge clk);
    start(1'b1, 32'hFFFF_FF00, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hazir", {31'd0, bus.hazir_o}, 32'd1);
    chk("arst_bolum", bus.bolum_o, 32'd0);
    chk("arst_kalan", bus.kalan_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_pulse("arst_no_pulse", 40);

    // Fresh operation after reset
    run("after_rst", 1'b1, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 32'hFFFF_FFFF, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
